// File: rtl/ts_pkg.sv
// Shared widths and the timestamp word type for the event time-tagger.
package ts_pkg;

    localparam int TS_CNT_W = 32;
    localparam int EPOCH_W  = 8;
    localparam int TS_W     = EPOCH_W + TS_CNT_W;

    typedef logic [TS_W-1:0] ts_word_t;

endpackage

// File: rtl/ts_fifo.sv
// First-word-fall-through FIFO with occupancy count; head word reads as zero when empty.
module ts_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int TS_W  = ts_pkg::TS_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            push,
    input  logic            pop,
    input  logic [TS_W-1:0] din,
    output logic [TS_W-1:0] dout,
    output logic            valid,
    output logic            full,
    output logic [AW:0]     level
);

    logic [TS_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    logic            pop_ok;
    logic            push_ok;

    always_comb begin
        pop_ok   = pop & (level_q != '0);
        push_ok  = push & ((level_q != (AW+1)'(DEPTH)) | pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push_ok && !pop_ok)      level_d = level_q + (AW+1)'(1);
            else if (!push_ok && pop_ok) level_d = level_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; the empty case is masked on the read side.
    always_ff @(posedge clk) begin
        if (push_ok && !clr) mem_q[wr_ptr_q] <= din;
    end

    assign valid = (level_q != '0);
    assign full  = (level_q == (AW+1)'(DEPTH));
    assign level = level_q;
    assign dout  = valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/ts_capture.sv
// Event time-tagger: synchronised edge detect on evt_in, {epoch, count} tags queued in a FWFT FIFO.
module ts_capture #(
    parameter int DEPTH       = 16,
    parameter int AW          = 4,
    parameter int EPOCH_W     = ts_pkg::EPOCH_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  clr,
    input  logic                                  ena,
    input  logic [ts_pkg::TS_CNT_W-1:0]           count,
    input  logic                                  pulse_full,
    input  logic                                  evt_in,
    input  logic                                  edge_sel,
    output logic [EPOCH_W+ts_pkg::TS_CNT_W-1:0]   ts_data,
    output logic                                  ts_valid,
    input  logic                                  ts_ready,
    output logic [AW:0]                           ts_level,
    output logic                                  ovf
);

    import ts_pkg::*;

    localparam int TW = EPOCH_W + TS_CNT_W;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   evt_d_q, evt_d_d;
    logic [EPOCH_W-1:0]     epoch_q, epoch_d;
    logic                   ovf_q, ovf_d;
    logic                   evt_s;
    logic                   evt_edge;
    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic [EPOCH_W-1:0]     tag_epoch;
    logic [TW-1:0]          tag;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], evt_in};
        evt_s     = sync_q[SYNC_STAGES-1];
        // Normal operation and clr both load evt_d from evt_s, so clr never fabricates an edge.
        evt_d_d   = evt_s;
        evt_edge  = edge_sel ? (~evt_s & evt_d_q) : (evt_s & ~evt_d_q);
        pop       = ts_valid & ts_ready;
        push      = evt_edge & ena & ~clr & (~fifo_full | pop);
        // An edge in the wrap-pulse cycle already belongs to the new epoch.
        tag_epoch = epoch_q + EPOCH_W'(pulse_full);
        tag       = {tag_epoch, count};

        epoch_d = epoch_q;
        if (clr)                    epoch_d = '0;
        else if (ena && pulse_full) epoch_d = epoch_q + EPOCH_W'(1);

        ovf_d = ovf_q;
        if (clr)                                         ovf_d = 1'b0;
        else if (evt_edge && ena && fifo_full && !pop)   ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            evt_d_q <= 1'b0;
            epoch_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            evt_d_q <= evt_d_d;
            epoch_q <= epoch_d;
            ovf_q   <= ovf_d;
        end
    end

    ts_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .TS_W  (TW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .din   (tag),
        .dout  (ts_data),
        .valid (ts_valid),
        .full  (fifo_full),
        .level (ts_level)
    );

    assign ovf = ovf_q;

endmodule

// File: tb/tb_ts_capture.sv
// Directed bench for ts_capture: the bench itself plays the 32-bit timer and the reader.
module tb_ts_capture;

    localparam int LAT = 2;  // sync stages from the cycle evt_in is seen to the capture cycle

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic        ena = 1'b0;
    logic [31:0] count = '0;
    logic        pulse_full = 1'b0;
    logic        evt_in = 1'b0;
    logic        edge_sel = 1'b0;
    logic [39:0] ts_data;
    logic        ts_valid;
    logic        ts_ready = 1'b0;
    logic [4:0]  ts_level;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    logic [39:0] exp_tag [17];
    logic [39:0] exp_x;
    logic [31:0] c0;

    ts_capture #(
        .DEPTH       (16),
        .AW          (4),
        .EPOCH_W     (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .ena        (ena),
        .count      (count),
        .pulse_full (pulse_full),
        .evt_in     (evt_in),
        .edge_sel   (edge_sel),
        .ts_data    (ts_data),
        .ts_valid   (ts_valid),
        .ts_ready   (ts_ready),
        .ts_level   (ts_level),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock; afterwards advance the timer model the way the real timer would.
    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (clr) begin
                count      = '0;
                pulse_full = 1'b0;
            end else if (ena) begin
                pulse_full = (count == 32'hFFFF_FFFF);
                count      = count + 32'd1;
            end else begin
                pulse_full = 1'b0;
            end
        end
    endtask

    task automatic rise_and_fall();
        evt_in = 1'b1;
        step(2);
        evt_in = 1'b0;
        step(2);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset state
        ena = 1'b1;
        step(3);
        chk("rst_valid", ts_valid, 0);
        chk("rst_level", ts_level, 0);
        chk("rst_data",  ts_data,  0);
        chk("rst_ovf",   ovf,      0);
        rst = 1'b1;

        // 1: rising edge as the timer leaves 100
        for (int i = 0; i < 200 && count != 32'd100; i++) step();
        chk("t1_reach100", count, 100);
        step();
        evt_in = 1'b1;
        step(3);
        chk("t1_valid", ts_valid, 1);
        chk("t1_data",  ts_data,  {8'd0, 32'd103});
        chk("t1_level", ts_level, 1);
        ts_ready = 1'b1;
        step();
        ts_ready = 1'b0;
        chk("t1_popped", ts_valid, 0);

        // 2: falling-edge select, 10-cycle high pulse
        evt_in = 1'b0;
        step(4);
        edge_sel = 1'b1;
        step(2);
        chk("t2_selchg", ts_level, 0);
        c0 = count;
        evt_in = 1'b1;
        step(10);
        chk("t2_norise", ts_level, 0);
        evt_in = 1'b0;
        step(3);
        chk("t2_level", ts_level, 1);
        chk("t2_data",  ts_data,  {8'd0, c0 + 32'd12});
        ts_ready = 1'b1;
        step();
        ts_ready = 1'b0;
        edge_sel = 1'b0;
        step(2);

        // 3: edge coincident with wrap, then epoch rollover after 256 wraps
        count = 32'hFFFF_FFFD;
        step();
        evt_in = 1'b1;
        step(2);
        chk("t3_wrapcyc", {pulse_full, count}, {1'b1, 32'd0});
        step();
        chk("t3_wraptag", ts_data, {8'd1, 32'd0});
        ts_ready = 1'b1;
        step();
        ts_ready = 1'b0;
        evt_in = 1'b0;
        step(4);
        exp_x = {8'd1, count + 32'(LAT)};
        evt_in = 1'b1;
        step(3);
        chk("t3_later", ts_data, exp_x);
        ts_ready = 1'b1;
        step();
        ts_ready = 1'b0;
        for (int i = 0; i < 255; i++) begin
            count = 32'hFFFF_FFFF;
            step();
        end
        step();
        evt_in = 1'b0;
        step(4);
        exp_x = {8'd0, count + 32'(LAT)};
        evt_in = 1'b1;
        step(3);
        chk("t3_epoch0", ts_data, exp_x);
        ts_ready = 1'b1;
        step();
        ts_ready = 1'b0;
        evt_in = 1'b0;
        step(4);

        // 4: 17 edges into a 16-deep FIFO, then push+pop at full
        for (int i = 0; i < 17; i++) begin
            exp_tag[i] = {8'd0, count + 32'(LAT)};
            rise_and_fall();
        end
        step(2);
        chk("t4_level",   ts_level, 16);
        chk("t4_ovf",     ovf,      1);
        chk("t4_head",    ts_data,  exp_tag[0]);
        exp_x = {8'd0, count + 32'(LAT)};
        evt_in = 1'b1;
        step(2);
        ts_ready = 1'b1;
        step();
        ts_ready = 1'b0;
        evt_in = 1'b0;
        chk("t4_pushpop", ts_level, 16);
        ts_ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("t4_order%0d", i), ts_data, exp_tag[i]);
            step();
        end
        chk("t4_last", ts_data, exp_x);
        step();
        ts_ready = 1'b0;
        chk("t4_empty",  ts_valid, 0);
        chk("t4_sticky", ovf,      1);

        // 5: ena=0 ignores edges; clr with half-full FIFO and evt_s high
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("t5_clrovf", ovf, 0);
        ena = 1'b0;
        for (int i = 0; i < 3; i++) rise_and_fall();
        step(3);
        chk("t5_noena_lvl", ts_level, 0);
        chk("t5_noena_ovf", ovf,      0);
        ena = 1'b1;
        count = 32'hFFFF_FFFF;
        step(2);
        for (int i = 0; i < 8; i++) rise_and_fall();
        step();
        chk("t5_half", ts_level, 8);
        evt_in = 1'b1;
        step(2);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("t5_clr_lvl", ts_level, 0);
        chk("t5_clr_ovf", ovf,      0);
        step(3);
        chk("t5_nospur", ts_level, 0);
        evt_in = 1'b0;
        step(3);
        exp_x = {8'd0, count + 32'(LAT)};
        evt_in = 1'b1;
        step(3);
        chk("t5_epoch0", ts_data, exp_x);
        ts_ready = 1'b1;
        step();
        ts_ready = 1'b0;
        evt_in = 1'b0;
        step(3);

        // 6: reset mid-drain
        count = 32'hFFFF_FFFF;
        step(2);
        for (int i = 0; i < 3; i++) rise_and_fall();
        step();
        chk("t6_fill", ts_level, 3);
        ts_ready = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("t6_valid", ts_valid, 0);
        chk("t6_level", ts_level, 0);
        chk("t6_data",  ts_data,  0);
        chk("t6_ovf",   ovf,      0);
        ts_ready = 1'b0;
        step(3);
        rst = 1'b1;
        step(3);
        chk("t6_quiet", ts_level, 0);
        exp_x = {8'd0, count + 32'(LAT)};
        evt_in = 1'b1;
        step(3);
        chk("t6_valid1", ts_valid, 1);
        chk("t6_tag",    ts_data,  exp_x);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
